// File: rtl/dds_pkg.sv
// Shared widths, waveform encodings and mid-scale constant for the DDS core.
package dds_pkg;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned PH_W   = 10;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned ROM_AW = 8;
  localparam int unsigned ROM_DW = 7;

  localparam logic [7:0] MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SAW    = 2'b11
  } wave_t;

endpackage

// File: rtl/sine_qrom.sv
// Quarter-wave sine magnitude ROM, 256 x 7, registered read.
module sine_qrom
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] mag
);

  // round(127 * sin(pi * i / 510)); i = 255 lands exactly on the peak
  function automatic logic [ROM_DW-1:0] rom_val(input int unsigned i);
    real r;
    r = 127.0 * $sin(3.141592653589793 * real'(i) / 510.0);
    return ROM_DW'($rtoi(r + 0.5));
  endfunction

  logic [ROM_DW-1:0] rom [2**ROM_AW];

  for (genvar g = 0; g < 2**ROM_AW; g++) begin : g_rom
    assign rom[g] = rom_val(g);
  end

  always_ff @(posedge clk) begin
    if (rst) mag <= '0;
    else     mag <= rom[addr];
  end

endmodule

// File: rtl/dds_core.sv
// DDS core: phase accumulator, wrap-synchronised config buffering, phase offset
// stage and four-waveform generator with a 3-stage output pipeline.
module dds_core
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned PH_W  = 10,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [ACC_W-1:0] fword_in,
  input  logic [PH_W-1:0]  pword_in,
  input  logic [1:0]       wave_sel,
  output logic [OUT_W-1:0] dds_out,
  output logic             valid,
  output logic             phase_wrap
);

  logic [ACC_W-1:0] acc, fw, fw_p;
  logic [PH_W-1:0]  pw, pw_p;
  wave_t            ws, ws_p;
  logic             pend;
  logic [1:0]       vcnt;

  logic [ACC_W:0]   sum_c;
  logic             apply_c;

  assign sum_c   = {1'b0, acc} + {1'b0, fw};
  // pending config lands on a wrap, or immediately while the accumulator is frozen
  assign apply_c = pend && (en ? sum_c[ACC_W] : 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      phase_wrap <= 1'b0;
      fw         <= '0;
      pw         <= '0;
      ws         <= WAVE_SINE;
      fw_p       <= '0;
      pw_p       <= '0;
      ws_p       <= WAVE_SINE;
      pend       <= 1'b0;
    end else begin
      if (en) acc <= sum_c[ACC_W-1:0];
      phase_wrap <= en & sum_c[ACC_W];
      if (apply_c) begin
        fw <= fw_p;
        pw <= pw_p;
        ws <= ws_p;
      end
      if (load) begin
        fw_p <= fword_in;
        pw_p <= pword_in;
        ws_p <= wave_t'(wave_sel);
        pend <= 1'b1;
      end else if (apply_c) begin
        pend <= 1'b0;
      end
    end
  end

  // valid rises on the third edge out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt  <= '0;
      valid <= 1'b0;
    end else if (!valid) begin
      if (vcnt == 2'd2) valid <= 1'b1;
      else              vcnt  <= vcnt + 2'd1;
    end
  end

  // Stage 1: offset phase
  logic [PH_W-1:0] ph;
  wave_t           ws_ph;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph    <= '0;
      ws_ph <= WAVE_SINE;
    end else begin
      ph    <= acc[ACC_W-1 -: PH_W] + pw;
      ws_ph <= ws;
    end
  end

  // Stage 2: ROM lookup in parallel with the arithmetic waveforms
  logic [PH_W-3:0]  addr_c;
  logic [ROM_DW-1:0] mag;
  logic [OUT_W-1:0] wave_c;
  logic [OUT_W-1:0] wave_wv;
  wave_t            ws_wv;
  logic             neg_wv;

  assign addr_c = ph[PH_W-2] ? ~ph[PH_W-3:0] : ph[PH_W-3:0];

  sine_qrom u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (addr_c),
    .mag  (mag)
  );

  always_comb begin
    wave_c = '0;
    case (ws_ph)
      WAVE_SQUARE: wave_c = ph[PH_W-1] ? '0 : '1;
      WAVE_TRI:    wave_c = ph[PH_W-1] ? ~ph[PH_W-2 -: OUT_W] : ph[PH_W-2 -: OUT_W];
      WAVE_SAW:    wave_c = ph[PH_W-1 -: OUT_W];
      default:     wave_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_wv <= '0;
      ws_wv   <= WAVE_SINE;
      neg_wv  <= 1'b0;
    end else begin
      wave_wv <= wave_c;
      ws_wv   <= ws_ph;
      neg_wv  <= ph[PH_W-1];
    end
  end

  // Stage 3: sine sign/offset and final select
  always_ff @(posedge clk) begin
    if (rst) begin
      dds_out <= OUT_W'(MIDSCALE);
    end else if (ws_wv == WAVE_SINE) begin
      dds_out <= neg_wv ? OUT_W'(MIDSCALE) - OUT_W'(mag)
                        : OUT_W'(MIDSCALE) + OUT_W'(mag);
    end else begin
      dds_out <= wave_wv;
    end
  end

endmodule
